// File: rtl/core_sleep_ctrl.sv
// Always-on core sleep controller: gates the core clock on a software
// request and wakes the core on masked interrupt/event pending lines.
module core_sleep_ctrl #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int WAKE_DLY_WIDTH = 8
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic                      irq_pending_i,
    input  logic                      event_pending_i,
    input  logic                      core_busy_i,
    output logic                      clock_en_o,
    output logic                      core_sleeping_o
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_WAIT     = 2'd1;
    localparam logic [1:0] ST_GATED    = 2'd2;
    localparam logic [1:0] ST_WAKE_DLY = 2'd3;

    localparam logic [1:0] REG_CTRL  = 2'd0;
    localparam logic [1:0] REG_MASK  = 2'd1;
    localparam logic [1:0] REG_DELAY = 2'd2;
    localparam logic [1:0] REG_CNT   = 2'd3;

    localparam logic [WAKE_DLY_WIDTH-1:0] DLY_ONE   = WAKE_DLY_WIDTH'(1);
    localparam logic [WAKE_DLY_WIDTH-1:0] DLY_RESET = WAKE_DLY_WIDTH'(4);

    logic [1:0]                state_q;
    logic [1:0]                state_d;
    logic                      abort_q;
    logic                      abort_d;
    logic [1:0]                mask_q;
    logic [WAKE_DLY_WIDTH-1:0] delay_q;
    logic [WAKE_DLY_WIDTH-1:0] dly_cnt_q;
    logic [WAKE_DLY_WIDTH-1:0] dly_cnt_d;
    logic [31:0]               sleep_cnt_q;
    logic [31:0]               sleep_cnt_d;

    logic       apb_wr;
    logic       apb_rd;
    logic [1:0] reg_sel;
    logic       sleep_req;
    logic       wake;
    logic       unused_apb;

    assign apb_wr    = PSEL & PENABLE & PWRITE;
    assign apb_rd    = PSEL & PENABLE & ~PWRITE;
    assign reg_sel   = PADDR[3:2];
    assign sleep_req = apb_wr & (reg_sel == REG_CTRL) & PWDATA[0];
    assign wake      = |(mask_q & {event_pending_i, irq_pending_i});
    assign unused_apb = ^{PADDR, PWDATA};

    assign PREADY  = 1'b1;
    assign PSLVERR = 1'b0;

    // Gated states are exactly those with state bit 1 set, so both
    // outputs come straight from a single flop and cannot glitch.
    assign clock_en_o      = ~state_q[1];
    assign core_sleeping_o = state_q[1];

    // Sleep FSM next state, abort flag and wake-delay counter.
    always_comb begin
        state_d   = state_q;
        abort_d   = abort_q;
        dly_cnt_d = dly_cnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (sleep_req) begin
                    if (wake) begin
                        abort_d = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        abort_d = 1'b0;
                    end
                end
            end
            ST_WAIT: begin
                if (wake) begin
                    state_d = ST_RUN;
                    abort_d = 1'b1;
                end else if (!core_busy_i) begin
                    state_d = ST_GATED;
                end
            end
            ST_GATED: begin
                if (wake) begin
                    if (delay_q == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d   = ST_WAKE_DLY;
                        dly_cnt_d = delay_q;
                    end
                end
            end
            ST_WAKE_DLY: begin
                dly_cnt_d = dly_cnt_q - DLY_ONE;
                if (dly_cnt_q == DLY_ONE) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Sleep cycle counter: a write clears it and beats a same-cycle
    // increment; it sticks at all-ones instead of wrapping.
    always_comb begin
        sleep_cnt_d = sleep_cnt_q;
        if (apb_wr && (reg_sel == REG_CNT)) begin
            sleep_cnt_d = '0;
        end else if (state_q[1] && (sleep_cnt_q != '1)) begin
            sleep_cnt_d = sleep_cnt_q + 32'd1;
        end
    end

    // State, flag and counter registers.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= ST_RUN;
            abort_q     <= 1'b0;
            dly_cnt_q   <= '0;
            sleep_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            abort_q     <= abort_d;
            dly_cnt_q   <= dly_cnt_d;
            sleep_cnt_q <= sleep_cnt_d;
        end
    end

    // Software-writable wake configuration, legal in every state.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            mask_q  <= 2'b11;
            delay_q <= DLY_RESET;
        end else if (apb_wr) begin
            if (reg_sel == REG_MASK) begin
                mask_q <= PWDATA[1:0];
            end
            if (reg_sel == REG_DELAY) begin
                delay_q <= PWDATA[WAKE_DLY_WIDTH-1:0];
            end
        end
    end

    // APB read mux; bus reads zero outside a read access phase.
    always_comb begin
        PRDATA = '0;
        if (apb_rd) begin
            unique case (reg_sel)
                REG_CTRL:  PRDATA = {27'd0, abort_q, 2'b00, state_q};
                REG_MASK:  PRDATA = {30'd0, mask_q};
                REG_DELAY: PRDATA = 32'(delay_q);
                REG_CNT:   PRDATA = sleep_cnt_q;
                default:   PRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_core_sleep_ctrl.sv
// Directed bench for core_sleep_ctrl: expected values are queued when
// the stimulus is applied and popped when the DUT output is sampled.
module tb_core_sleep_ctrl;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        irq_pending_i;
    logic        event_pending_i;
    logic        core_busy_i;
    logic        clock_en_o;
    logic        core_sleeping_o;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    core_sleep_ctrl #(
        .APB_ADDR_WIDTH(12),
        .WAKE_DLY_WIDTH(8)
    ) dut (
        .HCLK(HCLK),
        .HRESET(HRESET),
        .PADDR(PADDR),
        .PWDATA(PWDATA),
        .PWRITE(PWRITE),
        .PSEL(PSEL),
        .PENABLE(PENABLE),
        .PRDATA(PRDATA),
        .PREADY(PREADY),
        .PSLVERR(PSLVERR),
        .irq_pending_i(irq_pending_i),
        .event_pending_i(event_pending_i),
        .core_busy_i(core_busy_i),
        .clock_en_o(clock_en_o),
        .core_sleeping_o(core_sleeping_o)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        n_assert++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed %h expected <empty queue>", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
        end
    endtask

    task automatic apb_wr(input logic [1:0] off, input logic [31:0] d);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b1;
        PADDR   = {8'd0, off, 2'b00};
        PWDATA  = d;
        tick();
        PENABLE = 1'b1;
        tick();
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
    endtask

    task automatic apb_rd(input logic [1:0] off, input string tag);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = {8'd0, off, 2'b00};
        tick();
        PENABLE = 1'b1;
        #1;
        chk(tag, PRDATA);
        tick();
        PSEL    = 1'b0;
        PENABLE = 1'b0;
    endtask

    initial begin
        HRESET = 1'b1;
        PADDR = '0;
        PWDATA = '0;
        PWRITE = 1'b0;
        PSEL = 1'b0;
        PENABLE = 1'b0;
        irq_pending_i = 1'b0;
        event_pending_i = 1'b0;
        core_busy_i = 1'b0;
        tick();
        tick();
        HRESET = 1'b0;

        // reset state
        exp_q.push_back(32'd1); chk("rst_clk_en", 32'(clock_en_o));
        exp_q.push_back(32'd0); chk("rst_sleeping", 32'(core_sleeping_o));
        exp_q.push_back(32'd0); chk("idle_prdata", PRDATA);
        exp_q.push_back(32'd1); chk("pready", 32'(PREADY));
        exp_q.push_back(32'd0); chk("pslverr", 32'(PSLVERR));
        exp_q.push_back(32'h0); apb_rd(2'd0, "rst_ctrl");
        exp_q.push_back(32'h3); apb_rd(2'd1, "rst_mask");
        exp_q.push_back(32'h4); apb_rd(2'd2, "rst_delay");
        exp_q.push_back(32'h0); apb_rd(2'd3, "rst_cnt");

        // sleep entry: WAIT_IDLE after write edge, GATED one edge later
        apb_wr(2'd0, 32'd1);
        exp_q.push_back(32'd1); chk("wait_clk_en", 32'(clock_en_o));
        tick();
        exp_q.push_back(32'd0); chk("gated_clk_en", 32'(clock_en_o));
        exp_q.push_back(32'd1); chk("gated_sleeping", 32'(core_sleeping_o));
        exp_q.push_back(32'h2); apb_rd(2'd0, "gated_ctrl");

        // one-cycle irq pulse, 4 cycles of wake delay (3 gated cycles)
        irq_pending_i = 1'b1;
        tick();
        irq_pending_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'd0); chk("wdly_clk_en", 32'(clock_en_o));
            tick();
        end
        exp_q.push_back(32'd1); chk("wake_clk_en", 32'(clock_en_o));
        exp_q.push_back(32'd0); chk("wake_sleeping", 32'(core_sleeping_o));
        exp_q.push_back(32'd7); apb_rd(2'd3, "cnt_after_wake");

        // sleep request with event pending and unmasked -> abort
        event_pending_i = 1'b1;
        apb_wr(2'd0, 32'd1);
        exp_q.push_back(32'd1); chk("abort_clk_en", 32'(clock_en_o));
        exp_q.push_back(32'h10); apb_rd(2'd0, "abort_ctrl");
        apb_wr(2'd1, 32'd1);
        core_busy_i = 1'b1;
        apb_wr(2'd0, 32'd1);
        exp_q.push_back(32'h01); apb_rd(2'd0, "masked_ev_ctrl");
        core_busy_i = 1'b0;
        tick();
        exp_q.push_back(32'd0); chk("masked_gated", 32'(clock_en_o));
        apb_wr(2'd2, 32'd0);
        irq_pending_i = 1'b1;
        tick();
        irq_pending_i = 1'b0;
        event_pending_i = 1'b0;
        exp_q.push_back(32'd1); chk("dly0_wake", 32'(clock_en_o));

        // busy core, irq arrives while waiting for idle
        core_busy_i = 1'b1;
        apb_wr(2'd0, 32'd1);
        exp_q.push_back(32'h01); apb_rd(2'd0, "busy_ctrl");
        for (int i = 0; i < 10; i++) begin
            if (i == 5) irq_pending_i = 1'b1;
            exp_q.push_back(32'd1); chk("busy_clk_en", 32'(clock_en_o));
            tick();
        end
        irq_pending_i = 1'b0;
        core_busy_i = 1'b0;
        exp_q.push_back(32'h10); apb_rd(2'd0, "busy_abort");

        // saturation of the sleep counter
        force dut.sleep_cnt_q = 32'hFFFF_FFFD;
        tick();
        release dut.sleep_cnt_q;
        apb_wr(2'd0, 32'd1);
        tick();
        for (int i = 0; i < 4; i++) tick();
        exp_q.push_back(32'hFFFF_FFFF); apb_rd(2'd3, "cnt_sat");
        irq_pending_i = 1'b1;
        tick();
        irq_pending_i = 1'b0;
        exp_q.push_back(32'hFFFF_FFFF); apb_rd(2'd3, "cnt_sat_run");
        apb_wr(2'd3, 32'h1234_5678);
        exp_q.push_back(32'h0); apb_rd(2'd3, "cnt_clear");

        // clear coinciding with an increment
        apb_wr(2'd0, 32'd1);
        tick();
        tick();
        tick();
        PSEL = 1'b1;
        PWRITE = 1'b1;
        PENABLE = 1'b0;
        PADDR = 12'h00C;
        PWDATA = 32'hFFFF_FFFF;
        tick();
        PENABLE = 1'b1;
        irq_pending_i = 1'b1;
        tick();
        PSEL = 1'b0;
        PENABLE = 1'b0;
        PWRITE = 1'b0;
        irq_pending_i = 1'b0;
        exp_q.push_back(32'd1); chk("clr_wake_clk_en", 32'(clock_en_o));
        exp_q.push_back(32'h0); apb_rd(2'd3, "cnt_clr_vs_inc");

        // reset in WAKE_DLY with counter at 3
        apb_wr(2'd2, 32'd5);
        apb_wr(2'd0, 32'd1);
        tick();
        irq_pending_i = 1'b1;
        tick();
        irq_pending_i = 1'b0;
        tick();
        tick();
        exp_q.push_back(32'd1); chk("pre_rst_sleeping", 32'(core_sleeping_o));
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        exp_q.push_back(32'd1); chk("mid_rst_clk_en", 32'(clock_en_o));
        exp_q.push_back(32'd0); chk("mid_rst_sleeping", 32'(core_sleeping_o));
        exp_q.push_back(32'h0); apb_rd(2'd0, "mid_rst_ctrl");
        exp_q.push_back(32'h3); apb_rd(2'd1, "mid_rst_mask");
        exp_q.push_back(32'h4); apb_rd(2'd2, "mid_rst_delay");
        exp_q.push_back(32'h0); apb_rd(2'd3, "mid_rst_cnt");

        // fresh wake delay after reset is the reset value of 4
        apb_wr(2'd0, 32'd1);
        tick();
        irq_pending_i = 1'b1;
        tick();
        irq_pending_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'd0); chk("post_rst_wdly", 32'(clock_en_o));
            tick();
        end
        exp_q.push_back(32'd1); chk("post_rst_wake", 32'(clock_en_o));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
